// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector test controller: FSM state
// encoding and default sizing parameters.
package seq_pkg;

  localparam int PAT_W_DEF    = 16;
  localparam int CNT_W_DEF    = 8;
  localparam int TICK_DIV_DEF = 2048;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while enabled and strobes step_en
// on the terminal count so the detector advances once per sequence step.
module seq_tick_gen #(
  parameter int TICK_DIV = seq_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step_en
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_en = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/seq_test_controller.sv
// Streams a latched bit pattern into a sequence detector and counts its hits.
// Optional build macro SEQ_CTRL_AUTORESTART_EN: repeat runs until reset.
module seq_test_controller
  import seq_pkg::*;
#(
  parameter int PAT_W    = PAT_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] expected_hits,
  input  logic             det_y,
  output logic             seq_bit,
  output logic             step_en,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] hit_count
);

  localparam int SW = $clog2(PAT_W);
  localparam logic [SW-1:0] LAST_STEP = SW'(PAT_W - 1);

  seq_state_e       state_q;
  logic [PAT_W-1:0] sh_q;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] hit_d;
  logic [SW-1:0]    step_cnt_q;
  logic             pass_q;
  logic             pass_d;
  logic             busy_q;
  logic             done_q;
  logic             det_clr_q;
  logic             tick_en;
  logic             tick_clr;
  logic             hit_now;
`ifdef SEQ_CTRL_AUTORESTART_EN
  logic [PAT_W-1:0] pat_lat_q;
  logic             ran_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign tick_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign tick_clr = (state_q == ST_CLEAR);

  seq_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .en      (tick_en),
    .clr     (tick_clr),
    .step_en (step_en)
  );

  // det_y only matters on a strobe; anything between strobes is ignored.
  assign hit_now = tick_en & step_en & det_y;

  always_comb begin
    hit_d = hit_now ? sat_inc(hit_q) : hit_q;
`ifdef SEQ_CTRL_AUTORESTART_EN
    pass_d = (hit_d == exp_q) && (ran_q ? pass_q : 1'b1);
`else
    pass_d = (hit_d == exp_q);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      exp_q      <= '0;
      hit_q      <= '0;
      step_cnt_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      det_clr_q  <= 1'b0;
`ifdef SEQ_CTRL_AUTORESTART_EN
      pat_lat_q  <= '0;
      ran_q      <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      det_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_q      <= pattern;
            exp_q     <= expected_hits;
            hit_q     <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            det_clr_q <= 1'b1;
            state_q   <= ST_CLEAR;
`ifdef SEQ_CTRL_AUTORESTART_EN
            pat_lat_q <= pattern;
            ran_q     <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          step_cnt_q <= '0;
          state_q    <= ST_RUN;
        end
        ST_RUN: begin
          hit_q <= hit_d;
          if (step_en) begin
            sh_q <= {sh_q[PAT_W-2:0], 1'b0};
            if (step_cnt_q == LAST_STEP) begin
              step_cnt_q <= '0;
              state_q    <= ST_DRAIN;
            end else begin
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          hit_q <= hit_d;
          if (step_en) begin
            pass_q  <= pass_d;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
`ifdef SEQ_CTRL_AUTORESTART_EN
          // Restart with the same stimulus; pass stays sticky across runs.
          sh_q      <= pat_lat_q;
          hit_q     <= '0;
          ran_q     <= 1'b1;
          det_clr_q <= 1'b1;
          state_q   <= ST_CLEAR;
`else
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign seq_bit   = (state_q == ST_RUN) & sh_q[PAT_W-1];
  assign det_clr   = det_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_seq_test_controller.sv
// Directed bench for seq_test_controller with PAT_W=8, CNT_W=4, TICK_DIV=4.
module tb_seq_test_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] expected_hits;
  logic       det_y;
  logic       seq_bit;
  logic       step_en;
  logic       det_clr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] hit_count;

  int checks = 0;
  int errors = 0;
  int dmode  = 0;
  int step_idx = 0;
  logic seq_log [0:15];

  seq_test_controller #(
    .PAT_W    (8),
    .CNT_W    (4),
    .TICK_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .expected_hits (expected_hits),
    .det_y         (det_y),
    .seq_bit       (seq_bit),
    .step_en       (step_en),
    .det_clr       (det_clr),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .hit_count     (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // step_idx becomes the 1-based number of the strobe in progress at its negedge
  always @(negedge clk) begin
    if (step_en) begin
      if (step_idx < 16) seq_log[step_idx] = seq_bit;
      step_idx = step_idx + 1;
    end
  end

  assign det_y = (dmode == 2) ? 1'b1 :
                 (dmode == 1) ? (step_en && (step_idx == 3 || step_idx == 6)) :
                 (dmode == 3) ? !step_en :
                 (dmode == 4) ? (step_en && step_idx == 12) : 1'b0;

  task automatic do_run(input logic [7:0] pat, input logic [3:0] exph, input int mode,
                        input bit restart_pulse, output int done_k, output int ndone,
                        output int clr_k, output int nclr, output logic [3:0] hits_at,
                        output logic pass_at);
    @(negedge clk);
    dmode = mode; step_idx = 0; pattern = pat; expected_hits = exph; start = 1'b1;
    done_k = -1; ndone = 0; clr_k = -1; nclr = 0; hits_at = 4'hx; pass_at = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (restart_pulse && k == 10) start = 1'b1;
      if (restart_pulse && k == 11) start = 1'b0;
      if (done) begin
        ndone++;
        if (done_k < 0) begin done_k = k; hits_at = hit_count; pass_at = pass; end
      end
      if (det_clr) begin
        nclr++;
        if (clr_k < 0) clr_k = k;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (step_en !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step_en); end
    checks++; if (det_clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", det_clr); end
    checks++; if (hit_count !== 4'd0) begin errors++; $display("FAIL reset_hits got %0d want 0", hit_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (seq_bit !== 1'b0) begin errors++; $display("FAIL reset_seq got %b want 0", seq_bit); end
  endtask

  task automatic test_pattern;
    int dk, nd, ck, nc;
    logic [3:0] h;
    logic p;
    logic [8:0] exp_seq;
    exp_seq = 9'b101101100;
    do_run(8'hB6, 4'd2, 1, 1'b0, dk, nd, ck, nc, h, p);
    checks++; if (step_idx !== 9) begin errors++; $display("FAIL pat_steps got %0d want 9", step_idx); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seq_log[i] !== exp_seq[8-i]) begin
        errors++; $display("FAIL pat_seqbit%0d got %b want %b", i + 1, seq_log[i], exp_seq[8-i]);
      end
    end
    checks++; if (dk !== 38) begin errors++; $display("FAIL pat_done_cycle got %0d want 38", dk); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL pat_done_count got %0d want 1", nd); end
    checks++; if (ck !== 1 || nc !== 1) begin errors++; $display("FAIL pat_clr got k=%0d n=%0d want k=1 n=1", ck, nc); end
    checks++; if (h !== 4'd2) begin errors++; $display("FAIL pat_hits got %0d want 2", h); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL pat_pass got %b want 1", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pat_idle_busy got %b want 0", busy); end
    checks++; if (hit_count !== 4'd2 || pass !== 1'b1) begin
      errors++; $display("FAIL pat_hold got hits=%0d pass=%b want 2/1", hit_count, pass);
    end
  endtask

  task automatic test_all_hits;
    int dk, nd, ck, nc;
    logic [3:0] h;
    logic p;
    do_run(8'h5A, 4'd9, 2, 1'b0, dk, nd, ck, nc, h, p);
    checks++; if (h !== 4'd9) begin errors++; $display("FAIL all_hits got %0d want 9", h); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL all_pass got %b want 1", p); end
  endtask

  task automatic test_between_strobes;
    int dk, nd, ck, nc;
    logic [3:0] h;
    logic p;
    do_run(8'hFF, 4'd0, 3, 1'b0, dk, nd, ck, nc, h, p);
    checks++; if (h !== 4'd0) begin errors++; $display("FAIL between_hits got %0d want 0", h); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL between_pass got %b want 1", p); end
    do_run(8'h0F, 4'd1, 0, 1'b0, dk, nd, ck, nc, h, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL mismatch_pass got %b want 0", p); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mismatch_hold got %b want 0", pass); end
  endtask

  task automatic test_start_ignored;
    int dk, nd, ck, nc;
    logic [3:0] h;
    logic p;
    do_run(8'hB6, 4'd2, 1, 1'b1, dk, nd, ck, nc, h, p);
    checks++; if (dk !== 38) begin errors++; $display("FAIL busy_start_cycle got %0d want 38", dk); end
    checks++; if (nd !== 1 || nc !== 1) begin
      errors++; $display("FAIL busy_start_count got done=%0d clr=%0d want 1/1", nd, nc);
    end
  endtask

  task automatic test_reset_midrun;
    int k;
    int spurious;
    @(negedge clk);
    dmode = 2; step_idx = 0; pattern = 8'hB6; expected_hits = 4'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (step_idx < 3 && k < 100) begin @(negedge clk); k++; end
    checks++; if (step_idx !== 3) begin errors++; $display("FAIL mid_reach_steps got %0d want 3", step_idx); end
    @(negedge clk);
    checks++; if (hit_count !== 4'd3) begin errors++; $display("FAIL mid_prehits got %0d want 3", hit_count); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || step_en !== 1'b0 || seq_bit !== 1'b0 || hit_count !== 4'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b step=%b seq=%b hits=%0d want 0/0/0/0",
                         busy, step_en, seq_bit, hit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (step_en || det_clr || busy) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d want 0", spurious); end
    dmode = 0;
  endtask

`ifdef SEQ_CTRL_AUTORESTART_EN
  task automatic test_autorestart;
    int dks [0:2];
    int cks [0:2];
    logic ps [0:2];
    logic [3:0] hs [0:2];
    int nd, nc;
    int exp_dk [0:2];
    int exp_ck [0:2];
    logic exp_p [0:2];
    logic [3:0] exp_h [0:2];
    exp_dk = '{38, 76, 114}; exp_ck = '{1, 39, 77};
    exp_p = '{1'b1, 1'b0, 1'b0}; exp_h = '{4'd0, 4'd1, 4'd0};
    nd = 0; nc = 0;
    @(negedge clk);
    dmode = 4; step_idx = 0; pattern = 8'hC3; expected_hits = 4'd0; start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done && nd < 3) begin dks[nd] = k; ps[nd] = pass; hs[nd] = hit_count; nd++; end
      if (det_clr && nc < 3) begin cks[nc] = k; nc++; end
    end
    checks++; if (nd !== 3 || nc !== 3) begin
      errors++; $display("FAIL auto_counts got done=%0d clr=%0d want 3/3", nd, nc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < nd) begin
        checks++; if (dks[i] !== exp_dk[i]) begin errors++; $display("FAIL auto_done%0d got %0d want %0d", i, dks[i], exp_dk[i]); end
        checks++; if (ps[i] !== exp_p[i]) begin errors++; $display("FAIL auto_pass%0d got %b want %b", i, ps[i], exp_p[i]); end
        checks++; if (hs[i] !== exp_h[i]) begin errors++; $display("FAIL auto_hits%0d got %0d want %0d", i, hs[i], exp_h[i]); end
      end
      if (i < nc) begin
        checks++; if (cks[i] !== exp_ck[i]) begin errors++; $display("FAIL auto_clr%0d got %0d want %0d", i, cks[i], exp_ck[i]); end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dmode = 0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; expected_hits = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef SEQ_CTRL_AUTORESTART_EN
    test_autorestart();
`else
    test_pattern();
    test_all_hits();
    test_between_strobes();
    test_start_ignored();
`endif
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
